lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
- Load/store control stage that sits directly upstream of data_memory.
- Accepts byte-addressed load/store requests from the execute/mem pipeline stage and converts them into word-wide data_memory accesses.
- Handles byte and halfword accesses: read-modify-write for SB/SH; lane extraction and sign/zero extension for loads.
- Flags misaligned accesses; returns a single-cycle response to the pipeline.

Parameters:
- WORD_IDX_W, 10, width of the word index driven to data_memory (1024 words).
- DATA_W, 32, data width; only 32 is supported.

Ports:
- clk  in  1  system clock
- rst_n  in  1  synchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_op  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU, 101 SW, 110 SH, 111 SB
- req_addr  in  32  byte address
- req_wdata  in  32  store data; the SB/SH value is in the low bits
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  extended load data; 0 for stores and misaligned accesses
- resp_misaligned  out  1  valid with resp_valid; the access was dropped
- busy  out  1  high in any state other than IDLE (pipeline stall)
- mem_read  out  1  to data_memory memRead
- mem_write  out  1  to data_memory memWrite
- mem_address  out  32  to data_memory address; [WORD_IDX_W-1:0] = req_addr[WORD_IDX_W+1:2], upper bits 0
- mem_wdata  out  32  to data_memory write_data_memory
- mem_rdata  in  32  from data_memory read_data_memory (combinational, valid while mem_read=1)

Behaviour:
- States: IDLE, READ, WRITE, RESP.
- req_ready = (state==IDLE).
- On accept: latch op, addr, wdata.
  - Misaligned → RESP. Misaligned means LW/SW with addr[1:0]!=0, or LH/LHU/SH with addr[0]!=0.
  - Loads/SB/SH → READ.
  - SW → WRITE.
- READ: mem_read=1; capture mem_rdata into word_q at the clock edge.
  - Loads → RESP.
  - SB/SH → WRITE.
- WRITE: mem_write=1; mem_wdata drives:
  - SW: wdata_q.
  - SB/SH: word_q with the addressed lane replaced. The lane is byte k=addr[1:0] at bits [8k+7:8k], or halfword h=addr[1] at [16h+15:16h] (little-endian).
  - Next state → RESP.
- RESP: resp_valid=1 for exactly one cycle; next state → IDLE. No response back-pressure.
- Latency, counting the accept edge as T:
  - Loads: resp_valid during cycle T+2.
  - SW: T+2.
  - SB/SH: T+3.
  - Misaligned: T+1.
- Back-to-back throughput: the next request can be accepted in the cycle after RESP.
- Load result:
  - LB/LH sign-extend the selected lane.
  - LBU/LHU zero-extend.
  - LW passes the full word.
  - The result is registered and held on resp_rdata until the next RESP.
- mem_read=0 and mem_write=0 outside READ and WRITE.
- mem_address and mem_wdata are 0 in IDLE and RESP.
- Address bits above WORD_IDX_W+1 are ignored (aliasing); this is not an error.
- Misaligned requests issue no memory access and return resp_rdata=0.
- Reset: at any edge with rst_n=0:
  - state←IDLE.
  - resp_valid, resp_misaligned, resp_rdata, word_q and latched request regs ← 0.
- mem_write is combinationally gated by rst_n, so reset asserted during WRITE causes no write at that edge. An abandoned operation produces no response.
- busy=0 and req_ready=1 in the first cycle after reset deassertion.
- req_valid while busy is ignored; the requester holds it.

Decomposition:
- lsu_pkg holds:
  - op encoding constants (OP_LW..OP_SB)
  - state enum
  - helper constants BYTE_W=8 and HALF_W=16
- Sub-module lsu_lane_align is purely combinational:
  - Inputs: word, addr[1:0], op, store data.
  - Outputs: extended load value, merged store word, misaligned flag.
- The FSM and registers live in lsu_ctrl.

Test Plan:
- Write mem[5]=0x11223344 through the memory port. Then LB, addr 0x16 → resp_rdata=0x00000022, resp_valid at T+2, mem_address=5.
- Preload mem[3]=0xAABBCCDD. SB addr 0x0D, wdata 0x000000EE → READ then WRITE of 0xAABBEEDD; resp at T+3; a following LW at 0x0C returns 0xAABBEEDD.
- LH addr 0x0E on word 0x8001FFFF → 0xFFFF8001. LHU on the same address → 0x00008001.
- LW addr 0x02 → resp_misaligned=1 at T+1, resp_rdata=0, mem_read/mem_write never asserted.
- SH addr 0x0A with rst_n dropped in the WRITE cycle → memory unchanged, no resp_valid, state IDLE, req_ready=1 after reset.
- Back-to-back SW 0x10←0xCAFEBABE then LW 0x10 with req_valid held → second accept in the cycle after RESP; load returns 0xCAFEBABE.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store unit: op encodings, FSM states and lane widths.
package lsu_pkg;

  localparam logic [2:0] OP_LW  = 3'd0;
  localparam logic [2:0] OP_LH  = 3'd1;
  localparam logic [2:0] OP_LHU = 3'd2;
  localparam logic [2:0] OP_LB  = 3'd3;
  localparam logic [2:0] OP_LBU = 3'd4;
  localparam logic [2:0] OP_SW  = 3'd5;
  localparam logic [2:0] OP_SH  = 3'd6;
  localparam logic [2:0] OP_SB  = 3'd7;

  localparam int BYTE_W = 8;
  localparam int HALF_W = 16;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_t;

  function automatic logic is_sub_word_store(input logic [2:0] op);
    return (op == OP_SB) || (op == OP_SH);
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Combinational lane logic: load extraction/extension, store lane merge and alignment check.
module lsu_lane_align
  import lsu_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [DATA_W-1:0] word,
  input  logic [1:0]        addr,
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] load_data,
  output logic [DATA_W-1:0] merged,
  output logic              misaligned
);

  logic [BYTE_W-1:0] byte_lane;
  logic [HALF_W-1:0] half_lane;

  // Little-endian: byte k lives at bits [8k+7:8k], halfword h at [16h+15:16h].
  assign byte_lane = word[{addr, 3'b000} +: BYTE_W];
  assign half_lane = word[{addr[1], 4'b0000} +: HALF_W];

  always_comb begin
    load_data = word;
    case (op)
      OP_LH:   load_data = {{(DATA_W-HALF_W){half_lane[HALF_W-1]}}, half_lane};
      OP_LHU:  load_data = {{(DATA_W-HALF_W){1'b0}}, half_lane};
      OP_LB:   load_data = {{(DATA_W-BYTE_W){byte_lane[BYTE_W-1]}}, byte_lane};
      OP_LBU:  load_data = {{(DATA_W-BYTE_W){1'b0}}, byte_lane};
      default: load_data = word;
    endcase
  end

  always_comb begin
    merged = word;
    case (op)
      OP_SB:   merged[{addr, 3'b000} +: BYTE_W]     = store_data[BYTE_W-1:0];
      OP_SH:   merged[{addr[1], 4'b0000} +: HALF_W] = store_data[HALF_W-1:0];
      OP_SW:   merged = store_data;
      default: merged = word;
    endcase
  end

  always_comb begin
    misaligned = 1'b0;
    case (op)
      OP_LW, OP_SW:         misaligned = (addr != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = addr[0];
      default:              misaligned = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// Load/store control: turns byte-addressed requests into word accesses on data_memory,
// with read-modify-write for SB/SH and a single-cycle response pulse.
module lsu_ctrl
  import lsu_pkg::*;
#(
  parameter int WORD_IDX_W = 10,
  parameter int DATA_W     = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  output logic [DATA_W-1:0] resp_rdata,
  output logic              resp_misaligned,
  output logic              busy,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int ADDR_W = WORD_IDX_W + 2;

  state_t              state;
  logic [2:0]          op_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [DATA_W-1:0]   word_q;

  logic [DATA_W-1:0]   align_word;
  logic [1:0]          align_addr;
  logic [2:0]          align_op;
  logic [DATA_W-1:0]   align_store;
  logic [DATA_W-1:0]   load_data;
  logic [DATA_W-1:0]   merged;
  logic                misaligned;
  logic                unused_addr_bits;

  // Upper address bits simply alias onto the 1024-word array.
  assign unused_addr_bits = ^req_addr[31:ADDR_W];

  // In IDLE the aligner checks the incoming request; afterwards it works on the latched one.
  assign align_word  = (state == ST_READ) ? mem_rdata : word_q;
  assign align_addr  = (state == ST_IDLE) ? req_addr[1:0] : addr_q[1:0];
  assign align_op    = (state == ST_IDLE) ? req_op : op_q;
  assign align_store = (state == ST_IDLE) ? req_wdata : wdata_q;

  lsu_lane_align #(.DATA_W(DATA_W)) u_align (
    .word       (align_word),
    .addr       (align_addr),
    .op         (align_op),
    .store_data (align_store),
    .load_data  (load_data),
    .merged     (merged),
    .misaligned (misaligned)
  );

  assign req_ready   = (state == ST_IDLE);
  assign busy        = (state != ST_IDLE);
  assign mem_read    = (state == ST_READ);
  // Gated by reset so an in-flight write is abandoned at the reset edge.
  assign mem_write   = (state == ST_WRITE) && rst_n;
  assign mem_address = (state == ST_READ || state == ST_WRITE)
                       ? {{(32-WORD_IDX_W){1'b0}}, addr_q[ADDR_W-1:2]} : 32'd0;
  assign mem_wdata   = (state == ST_WRITE) ? merged : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= ST_IDLE;
      op_q            <= '0;
      addr_q          <= '0;
      wdata_q         <= '0;
      word_q          <= '0;
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      resp_rdata      <= '0;
    end else begin
      resp_valid      <= 1'b0;
      resp_misaligned <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            op_q    <= req_op;
            addr_q  <= req_addr[ADDR_W-1:0];
            wdata_q <= req_wdata;
            if (misaligned) begin
              state           <= ST_RESP;
              resp_valid      <= 1'b1;
              resp_misaligned <= 1'b1;
              resp_rdata      <= '0;
            end else if (req_op == OP_SW) begin
              state <= ST_WRITE;
            end else begin
              state <= ST_READ;
            end
          end
        end
        ST_READ: begin
          word_q <= mem_rdata;
          if (is_sub_word_store(op_q)) begin
            state <= ST_WRITE;
          end else begin
            state      <= ST_RESP;
            resp_valid <= 1'b1;
            resp_rdata <= load_data;
          end
        end
        ST_WRITE: begin
          state      <= ST_RESP;
          resp_valid <= 1'b1;
          resp_rdata <= '0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl: directed scenarios plus randomized traffic against a byte-level memory model.
module tb_lsu_ctrl;
  import lsu_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_op = 3'd0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_misaligned;
  logic        busy;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  int tests = 0;
  int fails = 0;

  logic [31:0] dmem    [0:1023];
  logic [31:0] ref_mem [0:1023];

  logic [31:0] o_rdata, o_addr, o_wdata;
  logic        o_mis, o_rd, o_wr;
  int          o_lat;

  always #5 clk = ~clk;

  lsu_ctrl #(.WORD_IDX_W(10), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_misaligned(resp_misaligned),
    .busy(busy), .mem_read(mem_read), .mem_write(mem_write), .mem_address(mem_address),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  assign mem_rdata = mem_read ? dmem[mem_address[9:0]] : 32'd0;
  always @(posedge clk) if (mem_write) dmem[mem_address[9:0]] <= mem_wdata;

  // Reference model: byte-granular memory semantics.
  function automatic int acc_size(input logic [2:0] op);
    if (op == OP_LW || op == OP_SW) return 4;
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return 2;
    return 1;
  endfunction

  function automatic bit ref_mis(input logic [2:0] op, input logic [31:0] addr);
    return (addr % acc_size(op)) != 0;
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] addr);
    if (ref_mis(op, addr)) return 1;
    if (op == OP_SB || op == OP_SH) return 3;
    return 2;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [31:0] addr);
    logic [31:0] w, b, h;
    w = ref_mem[addr[11:2]];
    b = (w >> (8 * addr[1:0])) & 32'hFF;
    h = (w >> (16 * addr[1])) & 32'hFFFF;
    case (op)
      OP_LB:   return (b >= 32'd128)   ? b - 32'd256   : b;
      OP_LBU:  return b;
      OP_LH:   return (h >= 32'd32768) ? h - 32'd65536 : h;
      OP_LHU:  return h;
      OP_LW:   return w;
      default: return 32'd0;
    endcase
  endfunction

  function automatic void ref_store(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    logic [31:0] w;
    w = ref_mem[addr[11:2]];
    for (int i = 0; i < acc_size(op); i++) begin
      int p;
      p = int'(addr[1:0]) + i;
      w[p*8 +: 8] = wdata[i*8 +: 8];
    end
    ref_mem[addr[11:2]] = w;
  endfunction

  task automatic do_req(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wdata);
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_addr = addr; req_wdata = wdata;
    @(posedge clk);
    #1 req_valid = 1'b0;
    o_lat = 99; o_rd = 1'b0; o_wr = 1'b0; o_addr = 32'd0; o_wdata = 32'd0;
    o_rdata = 32'hDEADDEAD; o_mis = 1'bx;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (mem_read) o_rd = 1'b1;
      if (mem_write) begin o_wr = 1'b1; o_wdata = mem_wdata; end
      if (mem_read || mem_write) o_addr = mem_address;
      if (resp_valid) begin
        o_lat = i; o_rdata = resp_rdata; o_mis = resp_misaligned;
        break;
      end
    end
    $display("[TB] op=%0d addr=%08h wdata=%08h -> lat=%0d rdata=%08h mis=%0b rd=%0b wr=%0b maddr=%0d",
             op, addr, wdata, o_lat, o_rdata, o_mis, o_rd, o_wr, o_addr);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests++;
    if ({busy, req_ready, resp_valid, resp_misaligned, mem_read, mem_write} !== 6'b010000) begin
      fails++;
      $display("FAIL reset_ctrl: got busy/ready/rv/mis/rd/wr=%06b want 010000",
               {busy, req_ready, resp_valid, resp_misaligned, mem_read, mem_write});
    end
    tests++;
    if (resp_rdata !== 32'd0 || mem_address !== 32'd0 || mem_wdata !== 32'd0) begin
      fails++;
      $display("FAIL reset_data: rdata=%08h maddr=%08h mwdata=%08h want all 0", resp_rdata, mem_address, mem_wdata);
    end
    rst_n = 1'b1;
    @(negedge clk);
    tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_release: busy=%0b ready=%0b want 0/1", busy, req_ready);
    end
    $display("[TB] reset released, busy=%0b ready=%0b", busy, req_ready);
  endtask

  task automatic test_lb();
    do_req(OP_SW, 32'h14, 32'h11223344); ref_store(OP_SW, 32'h14, 32'h11223344);
    tests++;
    if (o_lat !== 2 || o_wdata !== 32'h11223344 || o_addr !== 32'd5) begin
      fails++;
      $display("FAIL sw_preload: lat=%0d wdata=%08h maddr=%0d want 2/11223344/5", o_lat, o_wdata, o_addr);
    end
    do_req(OP_LB, 32'h16, 32'h0);
    tests++;
    if (o_rdata !== 32'h00000022 || o_lat !== 2 || o_addr !== 32'd5 || o_mis !== 1'b0) begin
      fails++;
      $display("FAIL lb: rdata=%08h lat=%0d maddr=%0d mis=%0b want 00000022/2/5/0", o_rdata, o_lat, o_addr, o_mis);
    end
  endtask

  task automatic test_sb_rmw();
    do_req(OP_SW, 32'h0C, 32'hAABBCCDD); ref_store(OP_SW, 32'h0C, 32'hAABBCCDD);
    do_req(OP_SB, 32'h0D, 32'h000000EE); ref_store(OP_SB, 32'h0D, 32'h000000EE);
    tests++;
    if (o_lat !== 3 || o_rd !== 1'b1 || o_wr !== 1'b1 || o_wdata !== 32'hAABBEEDD || o_rdata !== 32'd0) begin
      fails++;
      $display("FAIL sb_rmw: lat=%0d rd=%0b wr=%0b wdata=%08h rdata=%08h want 3/1/1/AABBEEDD/0",
               o_lat, o_rd, o_wr, o_wdata, o_rdata);
    end
    do_req(OP_LW, 32'h0C, 32'h0);
    tests++;
    if (o_rdata !== 32'hAABBEEDD || o_lat !== 2) begin
      fails++;
      $display("FAIL lw_after_sb: rdata=%08h lat=%0d want AABBEEDD/2", o_rdata, o_lat);
    end
  endtask

  task automatic test_halfword();
    do_req(OP_SW, 32'h0C, 32'h8001FFFF); ref_store(OP_SW, 32'h0C, 32'h8001FFFF);
    do_req(OP_LH, 32'h0E, 32'h0);
    tests++;
    if (o_rdata !== 32'hFFFF8001) begin
      fails++;
      $display("FAIL lh_sign: rdata=%08h want FFFF8001", o_rdata);
    end
    do_req(OP_LHU, 32'h0E, 32'h0);
    tests++;
    if (o_rdata !== 32'h00008001) begin
      fails++;
      $display("FAIL lhu_zero: rdata=%08h want 00008001", o_rdata);
    end
  endtask

  task automatic test_misaligned();
    do_req(OP_LW, 32'h02, 32'h0);
    tests++;
    if (o_mis !== 1'b1 || o_lat !== 1 || o_rdata !== 32'd0 || o_rd !== 1'b0 || o_wr !== 1'b0) begin
      fails++;
      $display("FAIL misaligned_lw: mis=%0b lat=%0d rdata=%08h rd=%0b wr=%0b want 1/1/0/0/0",
               o_mis, o_lat, o_rdata, o_rd, o_wr);
    end
    do_req(OP_SH, 32'h0B, 32'hFFFF);
    tests++;
    if (o_mis !== 1'b1 || o_lat !== 1 || o_wr !== 1'b0) begin
      fails++;
      $display("FAIL misaligned_sh: mis=%0b lat=%0d wr=%0b want 1/1/0", o_mis, o_lat, o_wr);
    end
  endtask

  task automatic test_reset_mid_write();
    bit saw_resp;
    do_req(OP_SW, 32'h08, 32'h12345678); ref_store(OP_SW, 32'h08, 32'h12345678);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SH; req_addr = 32'h0A; req_wdata = 32'h0000BEEF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    tests++;
    if (mem_write !== 1'b1) begin
      fails++;
      $display("FAIL rmw_write_phase: mem_write=%0b want 1", mem_write);
    end
    rst_n = 1'b0;
    #1;
    tests++;
    if (mem_write !== 1'b0) begin
      fails++;
      $display("FAIL write_gated: mem_write=%0b want 0", mem_write);
    end
    @(negedge clk);
    rst_n = 1'b1;
    saw_resp = 1'b0;
    tests++;
    if (busy !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_idle: busy=%0b ready=%0b want 0/1", busy, req_ready);
    end
    repeat (3) begin
      @(negedge clk);
      if (resp_valid) saw_resp = 1'b1;
    end
    tests++;
    if (saw_resp !== 1'b0 || req_ready !== 1'b1) begin
      fails++;
      $display("FAIL abort_no_resp: saw_resp=%0b ready=%0b want 0/1", saw_resp, req_ready);
    end
    $display("[TB] SH 0x0A aborted by reset in WRITE, saw_resp=%0b", saw_resp);
    do_req(OP_LW, 32'h08, 32'h0);
    tests++;
    if (o_rdata !== 32'h12345678) begin
      fails++;
      $display("FAIL abort_mem_intact: rdata=%08h want 12345678", o_rdata);
    end
  endtask

  task automatic test_back_to_back();
    int r1_lat, r2_lat;
    logic [31:0] r2_data;
    logic ready_in_resp, ready_after;
    int n;
    r1_lat = 99; r2_lat = 99; r2_data = 32'hDEADDEAD; n = 0;
    ready_in_resp = 1'bx; ready_after = 1'bx;
    ref_store(OP_SW, 32'h10, 32'hCAFEBABE);
    @(negedge clk);
    req_valid = 1'b1; req_op = OP_SW; req_addr = 32'h10; req_wdata = 32'hCAFEBABE;
    @(posedge clk);
    #1 req_op = OP_LW; req_wdata = 32'h0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        n++;
        if (n == 1) begin r1_lat = i; ready_in_resp = req_ready; end
        else if (n == 2) begin r2_lat = i; r2_data = resp_rdata; end
      end
      if (i == 3) begin
        ready_after = req_ready;
        @(posedge clk);
        #1 req_valid = 1'b0;
      end
    end
    req_valid = 1'b0;
    $display("[TB] back-to-back SW/LW: resp1 lat=%0d resp2 lat=%0d rdata=%08h", r1_lat, r2_lat, r2_data);
    tests++;
    if (r1_lat !== 2 || ready_in_resp !== 1'b0 || ready_after !== 1'b1) begin
      fails++;
      $display("FAIL b2b_accept: sw_lat=%0d ready_in_resp=%0b ready_after=%0b want 2/0/1",
               r1_lat, ready_in_resp, ready_after);
    end
    tests++;
    if (r2_lat !== 5 || r2_data !== 32'hCAFEBABE) begin
      fails++;
      $display("FAIL b2b_load: lat=%0d rdata=%08h want 5/CAFEBABE", r2_lat, r2_data);
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 80; n++) begin
      logic [2:0]  op;
      logic [31:0] addr, wdata, exp_rdata;
      bit          exp_mis;
      int          exp_lat;
      op    = 3'($urandom_range(0, 7));
      addr  = ($urandom_range(0, 3) << 12) | ($urandom_range(0, 15) * 4) | $urandom_range(0, 3);
      wdata = $urandom;
      exp_mis = ref_mis(op, addr);
      exp_lat = ref_lat(op, addr);
      exp_rdata = (exp_mis || op >= OP_SW) ? 32'd0 : ref_load(op, addr);
      do_req(op, addr, wdata);
      if (!exp_mis && op >= OP_SW) ref_store(op, addr, wdata);
      tests++;
      if (o_rdata !== exp_rdata || o_mis !== exp_mis || o_lat !== exp_lat) begin
        fails++;
        $display("FAIL rand_resp: op=%0d addr=%08h rdata=%08h mis=%0b lat=%0d want %08h/%0b/%0d",
                 op, addr, o_rdata, o_mis, o_lat, exp_rdata, exp_mis, exp_lat);
      end
      tests++;
      if (exp_mis ? (o_rd || o_wr) : (o_addr !== {22'd0, addr[11:2]})) begin
        fails++;
        $display("FAIL rand_mem: op=%0d addr=%08h rd=%0b wr=%0b maddr=%0d want word %0d (no access if misaligned)",
                 op, addr, o_rd, o_wr, o_addr, addr[11:2]);
      end
    end
    for (int w = 0; w < 16; w++) begin
      tests++;
      if (dmem[w] !== ref_mem[w]) begin
        fails++;
        $display("FAIL rand_memimage: word %0d got %08h want %08h", w, dmem[w], ref_mem[w]);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) begin
      dmem[i] = 32'd0;
      ref_mem[i] = 32'd0;
    end
    test_reset();
    test_lb();
    test_sb_rmw();
    test_halfword();
    test_misaligned();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
